// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution stream source.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_W = 2'd1,
        SEND_B = 2'd2,
        SEND_X = 2'd3
    } src_state_t;

    localparam logic [1:0] SEL_W = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_X = 2'd2;

    // Width needed to hold K values 0..maxk.
    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction

endpackage

// File: rtl/src_buf.sv
// Single-write / single-read register array with a registered read port.
// A write to the address being read in the same cycle is forwarded, so a
// read issued alongside a write returns the new word.
module src_buf #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 64,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = we && (32'(wr_addr) < DEPTH);

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read, advanced only on request so the word holds during stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (wr_ok && (wr_addr == rd_addr)) begin
                rd_data <= wr_data;
            end else begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/conv_stream_source.sv
// Convolution input stream source: buffers W, B and X from a host write
// port and streams them out as W (K*K words), B (1 word), X (R*C words).
// Optional macro CONV_SRC_TLAST_EN adds OUTPUT_TLAST on the final X beat.
//
//  state  | meaning
//  -------+----------------------------------------------
//  IDLE   | waiting for start; host writes accepted
//  SEND_W | streaming W[0..K*K-1]
//  SEND_B | streaming the single bias word
//  SEND_X | streaming X[0..R*C-1]; last accept -> IDLE
//
// The buffer read registers act as the output register: the next word is
// read on the same edge that accepts the current one, so a continuously
// ready sink sees one beat per cycle across phase changes.
module conv_stream_source
    import conv_pkg::*;
#(
    parameter int INW  = 18,
    parameter int R    = 8,
    parameter int C    = 8,
    parameter int MAXK = 5,
    localparam int K_BITS = k_bits(MAXK),
    localparam int XAW    = $clog2(R*C)
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [1:0]        load_sel,
    input  logic [XAW-1:0]    load_addr,
    input  logic [INW-1:0]    load_data,
    input  logic              start,
    input  logic [K_BITS-1:0] start_k,
    input  logic              start_new_w,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [INW-1:0]    OUTPUT_TDATA,
    output logic              OUTPUT_TVALID,
    output logic [K_BITS:0]   OUTPUT_TUSER,
    input  logic              OUTPUT_TREADY
`ifdef CONV_SRC_TLAST_EN
    ,
    output logic              OUTPUT_TLAST
`endif
);

    localparam int WAW = $clog2(MAXK*MAXK);
    localparam int CW  = (XAW > WAW) ? XAW : WAW;
    localparam logic [K_BITS-1:0] MAXK_K = K_BITS'(MAXK);
    localparam logic [CW-1:0]     X_LAST = CW'(R*C - 1);

    src_state_t        state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [CW-1:0]     w_last;
    logic [K_BITS-1:0] k_q;
    logic              new_w_q;
    logic              cfg_ld, done_nxt, err_nxt;
    logic              start_ok, beat, wr_ok;
    logic              w_we, x_we, w_rd_en, x_rd_en;
    logic [INW-1:0]    w_q, x_q, b_q;

    assign start_ok = start && (start_k != '0) && (start_k <= MAXK_K);
    assign beat     = OUTPUT_TVALID && OUTPUT_TREADY;
    assign w_last   = CW'(k_q) * CW'(k_q) - CW'(1);

    // Host writes only land while idle so an in-flight transfer is untouched.
    assign wr_ok = load_we && (state == IDLE);
    assign w_we  = wr_ok && (load_sel == SEL_W) && (32'(load_addr) < MAXK*MAXK);
    assign x_we  = wr_ok && (load_sel == SEL_X) && (32'(load_addr) < R*C);

    src_buf #(.WIDTH(INW), .DEPTH(MAXK*MAXK)) u_w_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (w_we),
        .wr_addr (WAW'(load_addr)),
        .wr_data (load_data),
        .rd_en   (w_rd_en),
        .rd_addr (cnt_nxt[WAW-1:0]),
        .rd_data (w_q)
    );

    src_buf #(.WIDTH(INW), .DEPTH(R*C)) u_x_buf (
        .clk     (clk),
        .reset   (reset),
        .we      (x_we),
        .wr_addr (load_addr),
        .wr_data (load_data),
        .rd_en   (x_rd_en),
        .rd_addr (cnt_nxt[XAW-1:0]),
        .rd_data (x_q)
    );

    // Bias register; load_addr is irrelevant for B.
    always_ff @(posedge clk) begin
        if (wr_ok && (load_sel == SEL_B)) begin
            b_q <= load_data;
        end
    end

    // State, beat index, latched transfer config and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            k_q     <= '0;
            new_w_q <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            if (cfg_ld) begin
                k_q     <= start_k;
                new_w_q <= start_new_w;
            end
        end
    end

    // Next state, next beat index and buffer read requests.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cfg_ld    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        w_rd_en   = 1'b0;
        x_rd_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        cfg_ld  = 1'b1;
                        cnt_nxt = '0;
                        if (start_new_w) begin
                            state_nxt = SEND_W;
                            w_rd_en   = 1'b1;
                        end else begin
                            state_nxt = SEND_X;
                            x_rd_en   = 1'b1;
                        end
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            SEND_W: begin
                if (beat) begin
                    if (cnt == w_last) begin
                        state_nxt = SEND_B;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        w_rd_en = 1'b1;
                    end
                end
            end
            SEND_B: begin
                if (beat) begin
                    state_nxt = SEND_X;
                    cnt_nxt   = '0;
                    x_rd_en   = 1'b1;
                end
            end
            SEND_X: begin
                if (beat) begin
                    if (cnt == X_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                        x_rd_en = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output data select; zero while idle.
    always_comb begin
        OUTPUT_TDATA = '0;
        case (state)
            SEND_W:  OUTPUT_TDATA = w_q;
            SEND_B:  OUTPUT_TDATA = b_q;
            SEND_X:  OUTPUT_TDATA = x_q;
            default: OUTPUT_TDATA = '0;
        endcase
    end

    assign OUTPUT_TVALID = (state != IDLE);
    assign OUTPUT_TUSER  = {k_q, new_w_q};
    assign busy          = (state != IDLE);

`ifdef CONV_SRC_TLAST_EN
    assign OUTPUT_TLAST = (state == SEND_X) && (cnt == X_LAST);
`endif

endmodule
